dpc_kflag_generator: RTL

- Producer of the flagged k-value stream consumed by the DPC correction stage.
- Passes a per-pixel k-value AXI-Stream (calibration gains, raster order) through a one-deep output register.
- Sets the k-word MSB at every pixel whose (y,x) coordinate appears in a programmable, raster-sorted bad-pixel table.
- Sits between the calibration-memory reader and the corrector's k input.

---
 rtl/dpc_kflag_generator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dpc_kflag_generator.sv
// Flags bad pixels in the raster-order k stream by walking a raster-sorted (y,x) table alongside the pixels.
// Optional: define DPC_KGEN_STATS_EN to implement the per-frame flag counter on frame_flag_cnt.
module dpc_kflag_generator #(
  parameter int K_WIDTH      = 16,
  parameter int CNT_WIDTH    = 10,
  parameter int FRAME_HEIGHT = 512,
  parameter int FRAME_WIDTH  = 640,
  parameter int MAX_BP       = 128,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_k_tvalid,
  output logic                     s_k_tready,
  input  logic [K_WIDTH-2:0]       s_k_tdata,
  input  logic                     s_k_tuser,
  input  logic                     s_k_tlast,
  output logic                     m_k_tvalid,
  input  logic                     m_k_tready,
  output logic [K_WIDTH-1:0]       m_k_tdata,
  output logic                     m_k_tuser,
  output logic                     m_k_tlast,
  input  logic                     enable,
  input  logic                     cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]    cfg_wr_addr,
  input  logic [2*CNT_WIDTH-1:0]   cfg_wr_data,
  input  logic [ADDR_WIDTH:0]      cfg_bp_count,
  output logic                     cfg_wr_err,
  output logic                     order_err,
  output logic [ADDR_WIDTH:0]      frame_flag_cnt
);

  if (ADDR_WIDTH != $clog2(MAX_BP) || FRAME_WIDTH > (1 << CNT_WIDTH) ||
      FRAME_HEIGHT > (1 << CNT_WIDTH)) begin : g_param_check
    $error("dpc_kflag_generator: inconsistent parameters");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_BP_W = (ADDR_WIDTH+1)'(MAX_BP);

  state_t                  state;
  logic [2*CNT_WIDTH-1:0]  bp_table [MAX_BP];
  logic [CNT_WIDTH-1:0]    x_cnt, y_cnt, cur_x, cur_y;
  logic [ADDR_WIDTH:0]     ptr, bp_cnt, cur_ptr, cur_cnt, bp_cnt_sat;
  logic [2*CNT_WIDTH-1:0]  entry, cur_pos;
  logic                    accept, sof, step, entry_valid, match, stale, flag, frame_end;
  logic                    wr_addr_oob, wr_ok;

  assign s_k_tready = !m_k_tvalid | m_k_tready;
  assign accept     = s_k_tvalid & s_k_tready;
  assign sof        = accept & s_k_tuser;
  assign step       = accept & (s_k_tuser | (state == RUN));

  // A SOF beat sees position (0,0), pointer 0 and the freshly latched count on its own cycle.
  assign bp_cnt_sat = (cfg_bp_count > MAX_BP_W) ? MAX_BP_W : cfg_bp_count;
  assign cur_x      = sof ? '0 : x_cnt;
  assign cur_y      = sof ? '0 : y_cnt;
  assign cur_ptr    = sof ? '0 : ptr;
  assign cur_cnt    = sof ? bp_cnt_sat : bp_cnt;
  assign cur_pos    = {cur_y, cur_x};

  assign entry       = bp_table[cur_ptr[ADDR_WIDTH-1:0]];
  assign entry_valid = step & (cur_ptr < cur_cnt);
  assign match       = entry_valid & (entry == cur_pos);
  assign stale       = entry_valid & (entry < cur_pos);
  assign flag        = match & enable;
  assign frame_end   = step & s_k_tlast & (cur_y == CNT_WIDTH'(FRAME_HEIGHT - 1));

  assign wr_addr_oob = {1'b0, cfg_wr_addr} >= MAX_BP_W;
  assign wr_ok       = cfg_wr_en & (state == IDLE) & ~wr_addr_oob;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      ptr        <= '0;
      bp_cnt     <= '0;
      order_err  <= 1'b0;
      cfg_wr_err <= 1'b0;
      m_k_tvalid <= 1'b0;
      m_k_tdata  <= '0;
      m_k_tuser  <= 1'b0;
      m_k_tlast  <= 1'b0;
    end else begin
      cfg_wr_err <= cfg_wr_en & ((state == RUN) | wr_addr_oob);
      if (accept) begin
        m_k_tvalid <= 1'b1;
        m_k_tdata  <= {flag, s_k_tdata};
        m_k_tuser  <= s_k_tuser;
        m_k_tlast  <= s_k_tlast;
      end else if (m_k_tready) begin
        m_k_tvalid <= 1'b0;
      end
      if (step) begin
        if (s_k_tlast) begin
          x_cnt <= '0;
          y_cnt <= cur_y + CNT_WIDTH'(1);
        end else begin
          x_cnt <= cur_x + CNT_WIDTH'(1);
          y_cnt <= cur_y;
        end
        ptr       <= (match | stale) ? cur_ptr + (ADDR_WIDTH+1)'(1) : cur_ptr;
        order_err <= sof ? 1'b0 : (order_err | stale);
        if (sof) bp_cnt <= bp_cnt_sat;
        state <= frame_end ? IDLE : RUN;
      end
    end
  end

  // The table has no reset so its contents survive a mid-frame reset.
  always_ff @(posedge aclk) begin
    if (wr_ok) bp_table[cfg_wr_addr] <= cfg_wr_data;
  end

`ifdef DPC_KGEN_STATS_EN
  logic [ADDR_WIDTH:0] flag_cnt, flag_base, flag_cnt_nxt;

  always_comb begin
    flag_base    = sof ? '0 : flag_cnt;
    flag_cnt_nxt = flag_base;
    if (flag && (flag_base < MAX_BP_W)) flag_cnt_nxt = flag_base + (ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      flag_cnt       <= '0;
      frame_flag_cnt <= '0;
    end else if (step) begin
      flag_cnt <= flag_cnt_nxt;
      if (frame_end) frame_flag_cnt <= flag_cnt_nxt;
    end
  end
`else
  assign frame_flag_cnt = '0;
`endif

endmodule
